// File: rtl/wb_dram_arb_pkg.sv
// Shared types and constants for the Wishbone DRAM port arbiter.
package wb_dram_arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY,
        ST_ERR  = ARB_ERR
    } arb_state_e;

    // Outstanding counter is sized for the largest supported MAX_OUTSTANDING.
    localparam int unsigned MAX_OUTSTANDING_LIMIT = 15;
    localparam int unsigned OUT_CNT_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

endpackage

// File: rtl/wb_dram_port_arbiter_rr_arbiter.sv
// Rotating-priority request picker: first requester strictly after last_i wins.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] last_i,
    output logic [N-1:0]     gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = PTR_W'((32'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dram_port_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone DRAM user port between masters.
// Define WB_DRAM_ARB_TIMEOUT_EN to build the no-response watchdog (bus error + ERR state).
module wb_dram_port_arbiter
    import wb_dram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADR_W           = 32,
    parameter int unsigned DAT_W           = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0]       m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0]       m_dat_w,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0]   m_sel,
    output logic [NUM_MASTERS-1:0]             m_stall,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic [DAT_W-1:0]                   m_dat_r,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [ADR_W-1:0]                   s_adr,
    output logic [DAT_W-1:0]                   s_dat_w,
    output logic [DAT_W/8-1:0]                 s_sel,
    input  logic                               s_stall,
    input  logic                               s_ack,
    input  logic                               s_err,
    input  logic [DAT_W-1:0]                   s_dat_r,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int unsigned SEL_W = DAT_W / 8;
    localparam int unsigned PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, arb_gnt;
    logic [PTR_W-1:0]       last_q, last_d, owner;
    logic [OUT_CNT_W-1:0]   outst_q, outst_d;

    logic             busy, live, full, can_issue, issue, take_resp, tmo;
    logic             cyc_g, stb_g, we_g;
    logic [ADR_W-1:0] adr_g;
    logic [DAT_W-1:0] dat_g;
    logic [SEL_W-1:0] sel_g;

    rr_arbiter #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_rr (
        .req_i  (m_cyc),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        owner = '0;
        cyc_g = 1'b0;
        stb_g = 1'b0;
        we_g  = 1'b0;
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner = PTR_W'(i);
                cyc_g = m_cyc[i];
                stb_g = m_stb[i];
                we_g  = m_we[i];
                adr_g = m_adr[i*ADR_W +: ADR_W];
                dat_g = m_dat_w[i*DAT_W +: DAT_W];
                sel_g = m_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign full      = (outst_q == OUT_CNT_W'(MAX_OUTSTANDING));
    assign can_issue = busy & cyc_g & stb_g & ~full;
    assign issue     = can_issue & ~s_stall;
    // Responses with nothing outstanding (or after an abort) are dropped here.
    assign take_resp = busy & cyc_g & (outst_q != '0) & (s_ack | s_err);
    assign live      = busy & cyc_g & ~tmo;

    assign s_cyc   = live;
    assign s_stb   = can_issue & ~tmo;
    assign s_we    = live & we_g;
    assign s_adr   = adr_g;
    assign s_dat_w = dat_g;
    assign s_sel   = sel_g;
    assign m_dat_r = s_dat_r;
    assign grant   = grant_q;

    assign m_ack   = grant_q & {NUM_MASTERS{take_resp & s_ack}};
    assign m_err   = grant_q & {NUM_MASTERS{(take_resp & s_err) | tmo}};
    assign m_stall = ~grant_q | {NUM_MASTERS{~busy | s_stall | full | tmo}};

`ifdef WB_DRAM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wdog_q, wdog_d;

    assign tmo = busy & cyc_g & (outst_q != '0) & ~issue & ~take_resp &
                 (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q + WD_W'(1);
        if (!busy || !cyc_g || issue || take_resp || (outst_q == '0) || tmo)
            wdog_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    localparam int unsigned TMO_UNUSED = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        outst_d = outst_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    grant_d = arb_gnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Owner dropping CYC ends (or aborts) the tenure; in-flight count is discarded.
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner;
                    outst_d = '0;
                end else if (tmo) begin
                    state_d = ST_ERR;
                    outst_d = '0;
                end else if (issue && !take_resp) begin
                    outst_d = outst_q + OUT_CNT_W'(1);
                end else if (!issue && take_resp) begin
                    outst_d = outst_q - OUT_CNT_W'(1);
                end
            end
            ST_ERR: begin
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                outst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= PTR_W'(NUM_MASTERS - 1);
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

endmodule
